// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl
// Compares two WIDTH-bit unsigned operands by walking their 2-bit pairs
// from MSB to LSB through an external combinational comparator slice.
// One pair is presented per clock.
//
// Build option: COMP_SEQ_EARLY_TERM_EN
//   defined   : scan stops at the first differing pair (variable latency)
//   undefined : scan always visits all NP pairs (fixed latency NP+1)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, a, b         compare request and operands (captured on accept)
//   slice_a, slice_b    current pair driven to the comparator slice
//   slice_eq/gt/lt      comparator slice flags
//   busy                high while scanning
//   done                one-cycle pulse, results valid
//   a_eq_b/a_gt_b/a_lt_b registered results, held until next accept
module comp_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic             slice_eq,
    input  logic             slice_gt,
    input  logic             slice_lt,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);

    localparam int NP = WIDTH / 2;
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
`ifndef COMP_SEQ_EARLY_TERM_EN
    // Set once the most significant differing pair has been recorded, so
    // less significant pairs cannot overwrite the result.
    logic             r_decided;
`endif

    // Split the captured operands into pairs so the slice mux is a plain
    // array select on the pair index.
    logic [1:0] w_pair_a [NP];
    logic [1:0] w_pair_b [NP];

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_pair
            assign w_pair_a[gi] = r_a[2*gi +: 2];
            assign w_pair_b[gi] = r_b[2*gi +: 2];
        end
    endgenerate

    logic w_scan;
    logic w_accept;

    assign w_scan   = (r_state == S_SCAN);
    assign w_accept = start && !w_scan;

    assign slice_a = w_scan ? w_pair_a[r_idx] : 2'b00;
    assign slice_b = w_scan ? w_pair_b[r_idx] : 2'b00;
    assign busy    = w_scan;
    assign done    = (r_state == S_DONE);
    assign a_eq_b  = r_eq;
    assign a_gt_b  = r_gt;
    assign a_lt_b  = r_lt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
`ifndef COMP_SEQ_EARLY_TERM_EN
            r_decided <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= IW'(NP - 1);
                        r_eq    <= 1'b0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
`ifndef COMP_SEQ_EARLY_TERM_EN
                        r_decided <= 1'b0;
`endif
                        r_state <= S_SCAN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SCAN: begin
`ifdef COMP_SEQ_EARLY_TERM_EN
                    if (!slice_eq) begin
                        // Flags are copied as delivered, even if inconsistent.
                        r_gt    <= slice_gt;
                        r_lt    <= slice_lt;
                        r_state <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_eq    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                    end
`else
                    if (!slice_eq && !r_decided) begin
                        r_gt      <= slice_gt;
                        r_lt      <= slice_lt;
                        r_decided <= 1'b1;
                    end
                    if (r_idx == '0) begin
                        // Equal only if neither an earlier pair nor this one differed.
                        if (slice_eq && !r_decided) begin
                            r_eq <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
module tb_comp_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int NP    = WIDTH / 2;
    localparam int LIMIT = 50;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             slice_eq;
    logic             slice_gt;
    logic             slice_lt;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural comparator slice
    assign slice_eq = (slice_a == slice_b);
    assign slice_gt = (slice_a >  slice_b);
    assign slice_lt = (slice_a <  slice_b);

    comp_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .slice_a  (slice_a),
        .slice_b  (slice_b),
        .slice_eq (slice_eq),
        .slice_gt (slice_gt),
        .slice_lt (slice_lt),
        .busy     (busy),
        .done     (done),
        .a_eq_b   (a_eq_b),
        .a_gt_b   (a_gt_b),
        .a_lt_b   (a_lt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {x == y, x > y, x < y};
    endfunction

    // Cycle (1 = first cycle after the accepting edge) in which done is high.
    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef COMP_SEQ_EARLY_TERM_EN
        for (int p = NP - 1; p >= 0; p--) begin
            if (((x >> (2 * p)) & 3) != ((y >> (2 * p)) & 3)) return (NP - p) + 1;
        end
        return NP + 1;
`else
        return NP + 1;
`endif
    endfunction

    // ---------------- stimulus helper (no checking) ----------------
    logic [1:0] seq_q [$];

    task automatic run_compare(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               output int cycles, output int busy_n, output logic [2:0] res);
        seq_q.delete();
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;   // operands may change after acceptance
        cycles = 1; busy_n = 0; res = 3'b000;
        while (!done && cycles < LIMIT) begin
            if (busy) begin
                busy_n++;
                seq_q.push_back(slice_a);
            end
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) cycles = -1;
        res = {a_eq_b, a_gt_b, a_lt_b};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, a_eq_b, a_gt_b, a_lt_b, slice_a, slice_b} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_init: got busy=%b done=%b res=%b%b%b sa=%b sb=%b want all 0",
                     busy, done, a_eq_b, a_gt_b, a_lt_b, slice_a, slice_b);
        end
        @(negedge clk) rst = 1'b0;
        $display("reset_init: busy=%b done=%b", busy, done);
    endtask

    task automatic test_equal();
        int cyc, bn; logic [2:0] res; logic [1:0] exp_p;
        run_compare(8'hA5, 8'hA5, cyc, bn, res);
        $display("equal A5/A5: cycles=%0d busy=%0d res=%b", cyc, bn, res);
        vectors++;
        if (cyc != NP + 1) begin miscompares++; $display("FAIL eq_latency: got %0d want %0d", cyc, NP + 1); end
        vectors++;
        if (bn != NP) begin miscompares++; $display("FAIL eq_busy: got %0d want %0d", bn, NP); end
        vectors++;
        if (res !== 3'b100) begin miscompares++; $display("FAIL eq_result: got %b want 100", res); end
        for (int i = 0; i < NP; i++) begin
            exp_p = 2'((8'hA5 >> (2 * (NP - 1 - i))) & 3);
            vectors++;
            if (i >= seq_q.size() || seq_q[i] !== exp_p) begin
                miscompares++;
                $display("FAIL eq_slice_seq[%0d]: got %b want %b", i,
                         (i < seq_q.size()) ? seq_q[i] : 2'bxx, exp_p);
            end
        end
    endtask

    task automatic test_pattern(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input string nm);
        int cyc, bn; logic [2:0] res;
        run_compare(x, y, cyc, bn, res);
        $display("%s %h/%h: cycles=%0d busy=%0d res=%b", nm, x, y, cyc, bn, res);
        vectors++;
        if (cyc != model_lat(x, y)) begin miscompares++; $display("FAIL %s_latency: got %0d want %0d", nm, cyc, model_lat(x, y)); end
        vectors++;
        if (bn != model_lat(x, y) - 1) begin miscompares++; $display("FAIL %s_busy: got %0d want %0d", nm, bn, model_lat(x, y) - 1); end
        vectors++;
        if (res !== model_res(x, y)) begin miscompares++; $display("FAIL %s_result: got %b want %b", nm, res, model_res(x, y)); end
        vectors++;
        if (seq_q.size() == 0 || seq_q[0] !== 2'(x >> (WIDTH - 2))) begin
            miscompares++;
            $display("FAIL %s_first_slice: got %b want %b", nm, (seq_q.size() > 0) ? seq_q[0] : 2'bxx, 2'(x >> (WIDTH - 2)));
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic saw_busy;
        @(negedge clk);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);                       // cycle 1: scanning
        saw_busy = busy;
        a = 8'h55; b = 8'h55; start = 1'b1;   // should be ignored
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < LIMIT) begin @(posedge clk); #1; cyc++; end
        $display("ignore 00/FF: busy_at_restart=%b cycles=%0d res=%b%b%b", saw_busy, cyc, a_eq_b, a_gt_b, a_lt_b);
        vectors++;
        if (saw_busy !== 1'b1) begin miscompares++; $display("FAIL ign_busy: got %b want 1", saw_busy); end
        vectors++;
        if (cyc != model_lat(8'h00, 8'hFF)) begin miscompares++; $display("FAIL ign_latency: got %0d want %0d", cyc, model_lat(8'h00, 8'hFF)); end
        vectors++;
        if ({a_eq_b, a_gt_b, a_lt_b} !== 3'b001) begin miscompares++; $display("FAIL ign_result: got %b%b%b want 001", a_eq_b, a_gt_b, a_lt_b); end
        // Start during the done cycle
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done_at_start: got %b want 1", done); end
        a = 8'h55; b = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done); end
        cyc = 1;
        while (!done && cyc < LIMIT) begin @(posedge clk); #1; cyc++; end
        $display("b2b 55/55: cycles=%0d res=%b%b%b", cyc, a_eq_b, a_gt_b, a_lt_b);
        vectors++;
        if (cyc != NP + 1) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", cyc, NP + 1); end
        vectors++;
        if ({a_eq_b, a_gt_b, a_lt_b} !== 3'b100) begin miscompares++; $display("FAIL b2b_result: got %b%b%b want 100", a_eq_b, a_gt_b, a_lt_b); end
    endtask

    task automatic test_async_reset();
        int dn;
        // Results are nonzero after the previous test; reset between edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("async_reset idle: busy=%b done=%b res=%b%b%b", busy, done, a_eq_b, a_gt_b, a_lt_b);
        vectors++;
        if ({busy, done, a_eq_b, a_gt_b, a_lt_b, slice_a, slice_b} !== 9'b0) begin
            miscompares++;
            $display("FAIL async_reset_idle: got busy=%b done=%b res=%b%b%b sa=%b sb=%b want all 0",
                     busy, done, a_eq_b, a_gt_b, a_lt_b, slice_a, slice_b);
        end
        @(negedge clk) rst = 1'b0;
        // Reset during SCAN with idx=2 (upper pairs equal so early exit cannot fire)
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #2;                   // idx now 2
        vectors++;
        if (busy !== 1'b1 || slice_a !== 2'b11) begin miscompares++; $display("FAIL scan_idx2: got busy=%b sa=%b want busy=1 sa=11", busy, slice_a); end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, slice_a, slice_b} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset_scan: got busy=%b done=%b sa=%b sb=%b want all 0", busy, done, slice_a, slice_b);
        end
        @(negedge clk) rst = 1'b0;
        dn = 0;
        repeat (8) begin @(posedge clk); #1; if (done || busy) dn++; end
        $display("after scan reset: active_cycles=%0d", dn);
        vectors++;
        if (dn != 0) begin miscompares++; $display("FAIL no_done_after_reset: got %0d active cycles want 0", dn); end
        test_pattern(8'h12, 8'h13, "post_reset");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x, y;
        int cyc, bn; logic [2:0] res;
        for (int n = 0; n < 40; n++) begin
            x = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = x ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: y = WIDTH'($urandom);
            endcase
            run_compare(x, y, cyc, bn, res);
            $display("rand %0d %h/%h: cycles=%0d res=%b", n, x, y, cyc, res);
            vectors++;
            if (res !== model_res(x, y) || cyc != model_lat(x, y) || bn != model_lat(x, y) - 1) begin
                miscompares++;
                $display("FAIL rand_%0d: got res=%b cyc=%0d busy=%0d want res=%b cyc=%0d busy=%0d",
                         n, res, cyc, bn, model_res(x, y), model_lat(x, y), model_lat(x, y) - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_pattern(8'hC0, 8'h40, "gt");
        test_pattern(8'h12, 8'h13, "lt");
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
